regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Single-owner controller in front of the W×2**D register file; it drives WriteEn, both address pointers, DataIn and the 4-bit OP microcode.
- Shares the file between the core writeback path and a debug read/write port, with core priority and bounded debug starvation.
- Sequences a zero-fill of every register after reset and on request, so no register is read while undefined.

Parameters:
W, 8, data path width
D, 4, register pointer width (2**D registers)
MAXWAIT, 4, max cycles a pending debug request may be blocked by core traffic (must be >= 1)

Ports:
Clk  input  1  clock, all state on rising edge
ResetN  input  1  asynchronous, active-low reset
ClearReq  input  1  pulse: start zero-fill sequence
Busy  output  1  high while zero-fill in progress
CoreReq  input  1  core writeback request
CoreOp  input  4  ALU opcode for this writeback
CoreAddrA  input  D  rd pointer
CoreAddrB  input  D  rs pointer (MOV ops)
CoreData  input  W  writeback data
CoreGnt  output  1  core transaction performed at this edge
DbgReq  input  1  debug request
DbgWr  input  1  1 = write, 0 = read
DbgAddr  input  D  debug register pointer
DbgWData  input  W  debug write data
DbgGnt  output  1  debug transaction performed at this edge
DbgRData  output  W  registered read data
DbgRValid  output  1  one-cycle pulse, DbgRData valid
RfDataOutA  input  W  register file read port A
RfWriteEn  output  1  register file write enable
RfAddrA  output  D  register file pointer A
RfAddrB  output  D  register file pointer B
RfDataIn  output  W  register file write data
RfOp  output  4  opcode to register file

Behaviour:
- States: CLEAR, RUN. ResetN low -> CLEAR, ClrPtr=0, WaitCnt=0, DbgRData=0, DbgRValid=0.
- CLEAR:
  - Busy=1; CoreGnt=DbgGnt=0.
  - RfWriteEn=1, RfOp=4'b0000 (plain write to RfAddrA), RfAddrA=ClrPtr, RfAddrB=0, RfDataIn=0.
  - ClrPtr increments each cycle.
  - At ClrPtr==2**D-1 the next state is RUN and ClrPtr returns to 0. The fill lasts exactly 2**D cycles.
  - ClearReq is ignored while in CLEAR.
- RUN: Busy=0. Grants are combinational in the same cycle; the requester holds its request and fields until granted.
- ClearReq high in RUN:
  - No grants that cycle and RfWriteEn=0.
  - Next state is CLEAR with ClrPtr=0.
  - Priority order: ClearReq over debug over core.
- Debug wins when DbgReq && (!CoreReq || WaitCnt>=MAXWAIT).
- Core wins when CoreReq and debug does not win.
- Core grant: RfWriteEn=1, RfOp=CoreOp, RfAddrA=CoreAddrA, RfAddrB=CoreAddrB, RfDataIn=CoreData.
  - The register file resolves the destination itself: R4 for opcode 1011, R2 for 0101/0110, rs/rd for the MOV opcodes 1000/1001.
- Debug write grant: RfWriteEn=1, RfOp=0000, RfAddrA=DbgAddr, RfDataIn=DbgWData.
- Debug read grant:
  - RfWriteEn=0, RfAddrA=DbgAddr.
  - DbgRData <= RfDataOutA at that edge; DbgRValid=1 the following cycle only.
  - Read-after-write in consecutive cycles returns the new value, because register file reads are combinational.
- No grant: RfWriteEn=0, RfOp=0000, all addresses and data 0.
- WaitCnt:
  - Increments (saturating at MAXWAIT) each RUN cycle with DbgReq && !DbgGnt.
  - Clears on DbgGnt or when DbgReq is low.
  - Held at 0 in CLEAR.
- Reset asserted mid-fill or mid-transaction: the fill restarts from ClrPtr=0 and a pending DbgRValid is dropped.

Decomposition:
- Shared package regfile_pkg holds:
  - opcode constants OP_SLT=4'b1011, OP_LDT=4'b0101, OP_LD=4'b0110, OP_MOVHL=4'b1000, OP_MOVLH=4'b1001, OP_NOP=4'b0000;
  - an enum state_t {CLEAR, RUN}.
- One natural sub-module: regfile_clear_seq (ClrPtr counter plus done flag). The arbitration logic stays inline.

Test Plan:
- Release ResetN -> Busy=1 for 16 cycles, RfAddrA walks 0..15 with RfDataIn=0 and RfWriteEn=1; then RUN; a debug read of R7 returns 0.
- RUN, CoreReq with Op=0000, AddrA=3, Data=8'h5A -> CoreGnt same cycle; a debug read of R3 next cycle gives DbgRData=8'h5A, DbgRValid for 1 cycle.
- CoreReq held high for 10 cycles plus DbgReq write R9=8'hC3 from cycle 0 -> core granted cycles 0..3, DbgGnt in cycle 4, core resumes in cycle 5; R9 reads 8'hC3.
- Core and debug request simultaneously with WaitCnt=0 -> core wins; with CoreReq low -> debug wins immediately.
- ClearReq together with CoreReq and DbgReq -> no grant and RfWriteEn=0; then 16 fill cycles; the previously written R3 reads 0; the requests are granted after Busy falls.
- ResetN pulsed low at fill cycle 9 -> Busy stays high, ClrPtr restarts at 0, and 16 full fill cycles follow the release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared opcodes and controller state encoding for the register-file front end.
package regfile_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LDT   = 4'b0101;
  localparam logic [3:0] OP_LD    = 4'b0110;
  localparam logic [3:0] OP_MOVHL = 4'b1000;
  localparam logic [3:0] OP_MOVLH = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1011;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Zero-fill pointer: walks every register once, Done flags the last one.
module regfile_clear_seq #(
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         En,
  output logic [D-1:0] ClrPtr,
  output logic         Done
);

  assign Done = (ClrPtr == {D{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ClrPtr <= '0;
    end else if (En) begin
      ClrPtr <= Done ? '0 : ClrPtr + D'(1);
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Single owner of the register file: zero-fill sequencer plus core/debug arbiter
// with core priority and bounded debug starvation.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter int MAXWAIT = 4
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         ClearReq,
  output logic         Busy,
  input  logic         CoreReq,
  input  logic [3:0]   CoreOp,
  input  logic [D-1:0] CoreAddrA,
  input  logic [D-1:0] CoreAddrB,
  input  logic [W-1:0] CoreData,
  output logic         CoreGnt,
  input  logic         DbgReq,
  input  logic         DbgWr,
  input  logic [D-1:0] DbgAddr,
  input  logic [W-1:0] DbgWData,
  output logic         DbgGnt,
  output logic [W-1:0] DbgRData,
  output logic         DbgRValid,
  input  logic [W-1:0] RfDataOutA,
  output logic         RfWriteEn,
  output logic [D-1:0] RfAddrA,
  output logic [D-1:0] RfAddrB,
  output logic [W-1:0] RfDataIn,
  output logic [3:0]   RfOp
);

  localparam int WW = $clog2(MAXWAIT + 1);

  state_t          state;
  state_t          nextState;
  logic            clrEn;
  logic            clrDone;
  logic [D-1:0]    clrPtr;
  logic [WW-1:0]   waitCnt;
  logic            dbgWin;

  regfile_clear_seq #(.D(D)) uClearSeq (
    .Clk    (Clk),
    .ResetN (ResetN),
    .En     (clrEn),
    .ClrPtr (clrPtr),
    .Done   (clrDone)
  );

  assign dbgWin = DbgReq && (!CoreReq || (waitCnt >= WW'(MAXWAIT)));

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= CLEAR;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    nextState = state;
    clrEn     = 1'b0;
    Busy      = 1'b0;
    CoreGnt   = 1'b0;
    DbgGnt    = 1'b0;
    RfWriteEn = 1'b0;
    RfOp      = OP_NOP;
    RfAddrA   = '0;
    RfAddrB   = '0;
    RfDataIn  = '0;
    unique case (state)
      CLEAR: begin
        Busy      = 1'b1;
        clrEn     = 1'b1;
        RfWriteEn = 1'b1;
        RfAddrA   = clrPtr;
        if (clrDone) nextState = RUN;
      end
      RUN: begin
        if (ClearReq) begin
          nextState = CLEAR;
        end else if (dbgWin) begin
          DbgGnt    = 1'b1;
          RfWriteEn = DbgWr;
          RfAddrA   = DbgAddr;
          if (DbgWr) RfDataIn = DbgWData;
        end else if (CoreReq) begin
          CoreGnt   = 1'b1;
          RfWriteEn = 1'b1;
          RfOp      = CoreOp;
          RfAddrA   = CoreAddrA;
          RfAddrB   = CoreAddrB;
          RfDataIn  = CoreData;
        end
      end
      default: nextState = CLEAR;
    endcase
  end

  // Starvation counter only runs while a debug request is actually being blocked.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      waitCnt <= '0;
    end else if (state != RUN || !DbgReq || DbgGnt) begin
      waitCnt <= '0;
    end else if (waitCnt != WW'(MAXWAIT)) begin
      waitCnt <= waitCnt + WW'(1);
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      DbgRData  <= '0;
      DbgRValid <= 1'b0;
    end else begin
      DbgRValid <= DbgGnt && !DbgWr;
      if (DbgGnt && !DbgWr) DbgRData <= RfDataOutA;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x8 register file behind it.
module tb_regfile_arbiter;

  localparam int W = 8;
  localparam int D = 4;

  logic         Clk;
  logic         ResetN;
  logic         ClearReq;
  logic         Busy;
  logic         CoreReq;
  logic [3:0]   CoreOp;
  logic [D-1:0] CoreAddrA;
  logic [D-1:0] CoreAddrB;
  logic [W-1:0] CoreData;
  logic         CoreGnt;
  logic         DbgReq;
  logic         DbgWr;
  logic [D-1:0] DbgAddr;
  logic [W-1:0] DbgWData;
  logic         DbgGnt;
  logic [W-1:0] DbgRData;
  logic         DbgRValid;
  logic [W-1:0] RfDataOutA;
  logic         RfWriteEn;
  logic [D-1:0] RfAddrA;
  logic [D-1:0] RfAddrB;
  logic [W-1:0] RfDataIn;
  logic [3:0]   RfOp;

  int checkCnt = 0;
  int failCnt  = 0;

  regfile_arbiter #(.W(W), .D(D), .MAXWAIT(4)) dut (
    .Clk(Clk), .ResetN(ResetN), .ClearReq(ClearReq), .Busy(Busy),
    .CoreReq(CoreReq), .CoreOp(CoreOp), .CoreAddrA(CoreAddrA), .CoreAddrB(CoreAddrB),
    .CoreData(CoreData), .CoreGnt(CoreGnt),
    .DbgReq(DbgReq), .DbgWr(DbgWr), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgGnt(DbgGnt), .DbgRData(DbgRData), .DbgRValid(DbgRValid),
    .RfDataOutA(RfDataOutA), .RfWriteEn(RfWriteEn), .RfAddrA(RfAddrA),
    .RfAddrB(RfAddrB), .RfDataIn(RfDataIn), .RfOp(RfOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file model: contents start unknown, combinational read on port A.
  logic [W-1:0] rfMem [16];
  logic [D-1:0] rfDest;
  always_comb begin
    case (RfOp)
      4'b1011:          rfDest = 4'd4;
      4'b0101, 4'b0110: rfDest = 4'd2;
      default:          rfDest = RfAddrA;
    endcase
  end
  always @(posedge Clk) if (RfWriteEn) rfMem[rfDest] <= RfDataIn;
  assign RfDataOutA = rfMem[RfAddrA];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: land just after the falling edge, inputs then settle.
  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic dbgRead(input logic [D-1:0] addr, input logic [W-1:0] exp);
    DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = addr;
    #1;
    for (int i = 0; i < 20 && !DbgGnt; i++) cyc();
    check("dbg_read_gnt", DbgGnt, 1);
    check("dbg_read_addr", RfAddrA, addr);
    cyc();
    DbgReq = 1'b0;
    #1;
    check("dbg_rvalid", DbgRValid, 1);
    check("dbg_rdata", DbgRData, exp);
    cyc();
    check("dbg_rvalid_pulse", DbgRValid, 0);
  endtask

  task automatic checkFill(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_busy"}, Busy, 1);
      check({tag, "_we"}, RfWriteEn, 1);
      check({tag, "_addr"}, RfAddrA, i);
      check({tag, "_data"}, RfDataIn, 0);
      check({tag, "_nogrant"}, {CoreGnt, DbgGnt}, 0);
      cyc();
    end
    check({tag, "_done"}, Busy, 0);
  endtask

  initial begin
    ResetN = 1'b0; ClearReq = 1'b0;
    CoreReq = 1'b0; CoreOp = 4'b0000; CoreAddrA = '0; CoreAddrB = '0; CoreData = '0;
    DbgReq = 1'b0; DbgWr = 1'b0; DbgAddr = '0; DbgWData = '0;
    cyc();
    check("rst_busy", Busy, 1);
    check("rst_rvalid", DbgRValid, 0);
    check("rst_rdata", DbgRData, 0);
    check("rst_addr", RfAddrA, 0);
    ResetN = 1'b1;
    #1;

    // Power-up fill, then R7 must read as zero.
    checkFill("fill0");
    dbgRead(4'd7, 8'h00);

    // Core write R3 = 5A, read back next cycle.
    CoreReq = 1'b1; CoreOp = 4'b0000; CoreAddrA = 4'd3; CoreData = 8'h5A;
    #1;
    check("core_gnt", CoreGnt, 1);
    check("core_we", RfWriteEn, 1);
    check("core_addr", RfAddrA, 3);
    check("core_data", RfDataIn, 8'h5A);
    check("core_dbg_gnt", DbgGnt, 0);
    cyc();
    CoreReq = 1'b0;
    dbgRead(4'd3, 8'h5A);

    // Sustained core traffic starves debug for exactly four cycles.
    CoreReq = 1'b1; CoreAddrA = 4'd5; CoreData = 8'h11;
    DbgReq = 1'b1; DbgWr = 1'b1; DbgAddr = 4'd9; DbgWData = 8'hC3;
    #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("starve_core_c%0d", c), CoreGnt, (c != 4));
      check($sformatf("starve_dbg_c%0d", c), DbgGnt, (c == 4));
      if (c == 4) begin
        check("starve_dbg_addr", RfAddrA, 9);
        check("starve_dbg_data", RfDataIn, 8'hC3);
        check("starve_dbg_we", RfWriteEn, 1);
      end
      cyc();
      if (c == 4) begin DbgReq = 1'b0; DbgWr = 1'b0; #1; end
    end
    CoreReq = 1'b0;
    dbgRead(4'd9, 8'hC3);
    dbgRead(4'd5, 8'h11);

    // Simultaneous requests with no wait history: core first, debug next.
    CoreReq = 1'b1; CoreOp = 4'b1011; CoreAddrA = 4'd6; CoreAddrB = 4'd1; CoreData = 8'h77;
    DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = 4'd3;
    #1;
    check("sim_core_gnt", CoreGnt, 1);
    check("sim_dbg_gnt", DbgGnt, 0);
    check("sim_op", RfOp, 4'b1011);
    check("sim_addrb", RfAddrB, 1);
    cyc();
    CoreReq = 1'b0; CoreOp = 4'b0000;
    #1;
    check("dbg_alone_gnt", DbgGnt, 1);
    check("dbg_alone_we", RfWriteEn, 0);
    cyc();
    DbgReq = 1'b0;
    #1;
    check("dbg_alone_rvalid", DbgRValid, 1);
    check("dbg_alone_rdata", DbgRData, 8'h5A);
    cyc();
    dbgRead(4'd4, 8'h77);

    // ClearReq beats both requesters; they are served once the fill ends.
    ClearReq = 1'b1;
    CoreReq = 1'b1; CoreAddrA = 4'd8; CoreData = 8'h99;
    DbgReq = 1'b1; DbgWr = 1'b1; DbgAddr = 4'd10; DbgWData = 8'h44;
    #1;
    check("clr_no_core", CoreGnt, 0);
    check("clr_no_dbg", DbgGnt, 0);
    check("clr_no_we", RfWriteEn, 0);
    check("clr_busy_low", Busy, 0);
    cyc();
    ClearReq = 1'b0;
    #1;
    checkFill("fill1");
    check("post_clr_core", CoreGnt, 1);
    check("post_clr_dbg_wait", DbgGnt, 0);
    cyc();
    CoreReq = 1'b0;
    #1;
    check("post_clr_dbg", DbgGnt, 1);
    check("post_clr_dbg_we", RfWriteEn, 1);
    cyc();
    DbgReq = 1'b0; DbgWr = 1'b0;
    dbgRead(4'd3, 8'h00);
    dbgRead(4'd8, 8'h99);
    dbgRead(4'd10, 8'h44);

    // Reset right after a read grant drops the pending valid.
    DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = 4'd8;
    #1;
    check("rr_gnt", DbgGnt, 1);
    cyc();
    DbgReq = 1'b0;
    ResetN = 1'b0;
    #1;
    check("rr_rvalid_drop", DbgRValid, 0);
    check("rr_rdata_clr", DbgRData, 0);
    check("rr_busy", Busy, 1);
    cyc();
    ResetN = 1'b1;
    #1;

    // Reset at fill cycle 9 restarts the fill from pointer 0.
    for (int i = 0; i < 9; i++) cyc();
    check("mid_fill_ptr9", RfAddrA, 9);
    ResetN = 1'b0;
    #1;
    check("mid_fill_busy", Busy, 1);
    check("mid_fill_ptr0", RfAddrA, 0);
    cyc();
    ResetN = 1'b1;
    #1;
    checkFill("fill2");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
    $finish;
  end

endmodule
